// File: rtl/ysyx_icache_pkg.sv
// ysyx_icache_pkg: shared definitions for the IFU instruction cache.
//   - FSM state encoding
//   - line geometry (words per line, byte-offset width)
//   - default cacheable window, alongside the bus address map
package ysyx_icache_pkg;

    localparam int unsigned WORDS_PER_LINE = 4;
    localparam int unsigned OFFSET_W       = 4;  // byte offset within a 16-byte line
    localparam int unsigned WORD_IDX_W     = 2;  // word select within a line

    // Cacheable window defaults (flash/SDRAM region of the bus map).
    localparam logic [31:0] ICACHE_LO_DEFAULT = 32'h3000_0000;
    localparam logic [31:0] ICACHE_HI_DEFAULT = 32'h3fff_ffff;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRefill = 2'd1,
        StBypass = 2'd2,
        StResp   = 2'd3
    } icache_state_e;

endpackage

// File: rtl/ysyx_icache_array.sv
// ysyx_icache_array: valid/tag/data storage for the direct-mapped icache.
// Ports:
//   clk, rst     clock, synchronous active-high reset (clears valid bits)
//   flush        clear every valid bit at the next edge; wins over a write
//   rd_index     combinational read port: rd_valid, rd_tag, rd_line
//   wr_*         one-line write port (tag, valid bit, full line of data)
module ysyx_icache_array import ysyx_icache_pkg::*; #(
    parameter int unsigned SET_W  = 4,
    parameter int unsigned TAG_W  = 24,
    parameter int unsigned DATA_W = 32
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    flush,
    input  logic [SET_W-1:0]                        rd_index,
    output logic                                    rd_valid,
    output logic [TAG_W-1:0]                        rd_tag,
    output logic [WORDS_PER_LINE-1:0][DATA_W-1:0]   rd_line,
    input  logic                                    wr_en,
    input  logic [SET_W-1:0]                        wr_index,
    input  logic [TAG_W-1:0]                        wr_tag,
    input  logic                                    wr_valid,
    input  logic [WORDS_PER_LINE-1:0][DATA_W-1:0]   wr_line
);

    localparam int unsigned SETS = 2 ** SET_W;

    logic [SETS-1:0]                          valid_q;
    logic [TAG_W-1:0]                         tag_q  [SETS];
    logic [WORDS_PER_LINE-1:0][DATA_W-1:0]    data_q [SETS];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= wr_valid;
        end
    end

    // Tag/data carry no reset; they are meaningless while the valid bit is 0.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_line;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_line  = data_q[rd_index];

endmodule

// File: rtl/ysyx_icache.sv
// ysyx_icache: direct-mapped instruction cache between IFU and the bus arbiter.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid, req_addr      fetch request (held until rsp_valid)
//   rsp_valid, rsp_inst      one-cycle response pulse with the instruction
//   fence_i                  invalidate all lines
//   mem_araddr, mem_arvalid  single-beat read request to the arbiter
//   mem_rdata, mem_rvalid    read data from the arbiter, one word per pulse
//   hit_cnt, miss_cnt        cacheable hit/miss counters (wrapping)
module ysyx_icache import ysyx_icache_pkg::*; #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       SET_W    = 4,
    parameter logic [ADDR_W-1:0] CACHE_LO = ICACHE_LO_DEFAULT,
    parameter logic [ADDR_W-1:0] CACHE_HI = ICACHE_HI_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_inst,
    input  logic              fence_i,
    output logic [ADDR_W-1:0] mem_araddr,
    output logic              mem_arvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);

    localparam int unsigned TAG_W  = ADDR_W - SET_W - OFFSET_W;
    localparam int unsigned LINE_W = ADDR_W - OFFSET_W;

    typedef logic [WORDS_PER_LINE-1:0][DATA_W-1:0] line_t;

    icache_state_e           state_q;
    logic [LINE_W-1:0]       line_addr_q;   // line-aligned miss address
    logic [WORD_IDX_W-1:0]   word_q;        // requested word of the miss
    logic [WORD_IDX_W-1:0]   beat_q;
    line_t                   line_buf_q;
    logic                    pend_flush_q;

    // Request decode and hit detection (combinational on req_addr).
    logic [TAG_W-1:0]        req_tag;
    logic [SET_W-1:0]        req_index;
    logic [WORD_IDX_W-1:0]   req_word;
    logic                    cacheable;
    logic                    rd_valid;
    logic [TAG_W-1:0]        rd_tag;
    line_t                   rd_line;
    logic                    hit;

    assign req_tag   = req_addr[ADDR_W-1 -: TAG_W];
    assign req_index = req_addr[OFFSET_W +: SET_W];
    assign req_word  = req_addr[2 +: WORD_IDX_W];
    assign cacheable = (req_addr >= CACHE_LO) && (req_addr <= CACHE_HI);
    assign hit       = cacheable && rd_valid && (rd_tag == req_tag);

    // Refill completion and the assembled line including the final beat.
    logic  refill_last;
    line_t fill_line;
    logic  flush;
    logic  flush_pending;

    assign refill_last   = (state_q == StRefill) && mem_rvalid && (beat_q == 2'd3);
    assign flush_pending = pend_flush_q || fence_i;

    always_comb begin
        fill_line         = line_buf_q;
        fill_line[beat_q] = mem_rdata;
    end

    // A fence seen during a refill is deferred to the refill's final edge so the
    // line being filled cannot end up valid with a stale view of memory.
    always_comb begin
        flush = 1'b0;
        if (state_q == StRefill) begin
            flush = refill_last && flush_pending;
        end else begin
            flush = fence_i;
        end
    end

    ysyx_icache_array #(
        .SET_W  (SET_W),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .rd_index (req_index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .wr_en    (refill_last && !rst),
        .wr_index (line_addr_q[SET_W-1:0]),
        .wr_tag   (line_addr_q[LINE_W-1 -: TAG_W]),
        .wr_valid (!flush_pending),
        .wr_line  (fill_line)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            line_addr_q  <= '0;
            word_q       <= '0;
            beat_q       <= '0;
            line_buf_q   <= '0;
            pend_flush_q <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_inst     <= '0;
            mem_arvalid  <= 1'b0;
            mem_araddr   <= '0;
            hit_cnt      <= '0;
            miss_cnt     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        if (hit) begin
                            rsp_inst  <= rd_line[req_word];
                            rsp_valid <= 1'b1;
                            hit_cnt   <= hit_cnt + 32'd1;
                            state_q   <= StResp;
                        end else if (cacheable) begin
                            line_addr_q  <= req_addr[ADDR_W-1:OFFSET_W];
                            word_q       <= req_word;
                            beat_q       <= '0;
                            pend_flush_q <= 1'b0;
                            miss_cnt     <= miss_cnt + 32'd1;
                            mem_arvalid  <= 1'b1;
                            mem_araddr   <= {req_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                            state_q      <= StRefill;
                        end else begin
                            mem_arvalid <= 1'b1;
                            mem_araddr  <= req_addr;
                            state_q     <= StBypass;
                        end
                    end
                end
                StRefill: begin
                    if (fence_i) begin
                        pend_flush_q <= 1'b1;
                    end
                    if (mem_rvalid) begin
                        line_buf_q[beat_q] <= mem_rdata;
                        beat_q             <= beat_q + 2'd1;
                        if (beat_q == 2'd3) begin
                            mem_arvalid  <= 1'b0;
                            rsp_inst     <= fill_line[word_q];
                            rsp_valid    <= 1'b1;
                            pend_flush_q <= 1'b0;
                            state_q      <= StResp;
                        end else begin
                            mem_araddr <= {line_addr_q, beat_q + 2'd1, 2'b00};
                        end
                    end
                end
                StBypass: begin
                    if (mem_rvalid) begin
                        mem_arvalid <= 1'b0;
                        rsp_inst    <= mem_rdata;
                        rsp_valid   <= 1'b1;
                        state_q     <= StResp;
                    end
                end
                StResp: begin
                    rsp_valid <= 1'b0;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
